icache_refill: RTL
==================

// Module: icache_refill
// PURPOSE
//  Miss-refill engine feeding the instruction cache's write port. On an IF-stage miss, it fetches
//  one 32-bit instruction as four byte reads from the byte-wide memory bus and assembles it
//  little-endian. It then pulses the cache write port and, in the same cycle, hands the word to IF.
//  Sits between the IF stage, the icache write port and the memory arbiter.
// PARAMETERS
//  ADDR_W   32   width of PCs and memory addresses
// PORTS
//  clk            in   1       system clock
//  rst            in   1       asynchronous, active-high reset
//  rdy            in   1       global ready; low = freeze all state and outputs
//  fetch_req_i    in   1       IF requests refill of fetch_pc_i
//  fetch_pc_i     in   ADDR_W  PC to refill (word aligned)
//  icache_hit_i   in   1       icache lookup hit for fetch_pc_i
//  flush_i        in   1       pipeline flush; abort any refill
//  mem_req_o      out  1       bus request to arbiter
//  mem_gnt_i      in   1       bus grant from arbiter
//  mem_a_o        out  ADDR_W  byte address to memory
//  mem_din_i      in   8       read byte; valid one cycle after its address
//  cache_we_o     out  1       icache write enable (1-cycle pulse)
//  cache_wpc_o    out  ADDR_W  icache write PC
//  cache_winst_o  out  32      icache write data
//  inst_valid_o   out  1       refilled instruction valid to IF (1-cycle pulse)
//  inst_o         out  32      refilled instruction
//  busy_o         out  1       high in any state except IDLE
// BEHAVIOUR
//  - Reset (async, rst=1): state=IDLE, all outputs and internal regs = 0.
//  - All updates occur only when rdy=1; rdy=0 holds every register, including FSM, counters,
//    address and data. flush_i is ignored while rdy=0.
//  - States: IDLE -> WAIT_GNT -> BUS -> TAIL -> DONE -> IDLE.
//  - IDLE: if fetch_req_i && !icache_hit_i, latch base=fetch_pc_i, go to WAIT_GNT.
//    A request with icache_hit_i=1 is ignored.
//  - WAIT_GNT: mem_req_o=1; if mem_gnt_i sampled 1, go to BUS with cnt=0.
//  - BUS: mem_a_o=base+cnt, cnt increments each cycle (2-bit). The byte arriving on mem_din_i
//    in BUS/TAIL is written to word[8*(cnt-1)+:8]. After cnt=3 is driven, go to TAIL.
//  - TAIL: capture byte 3 into word[31:24], go to DONE. mem_a_o holds base+3.
//  - DONE: cache_we_o=1, inst_valid_o=1, cache_wpc_o=base, cache_winst_o=inst_o=word,
//    mem_req_o=0, then go to IDLE.
//  - mem_req_o=1 in WAIT_GNT, BUS and TAIL; 0 elsewhere. Grant is not rechecked after BUS entry.
//  - Latency: if the grant is sampled in cycle n, the addresses go out in n+1..n+4, byte 3 is
//    captured in n+5, and the write pulse occurs in n+6.
//  - The base is latched; changes on fetch_pc_i during a refill have no effect.
//  - flush_i=1 (rdy=1) in any state: next state IDLE, mem_req_o drops next cycle, and there is no
//    cache_we_o or inst_valid_o pulse. A flush in DONE suppresses that cycle's pulses
//    (combinational gate).
//  - DONE->IDLE: a new request is accepted no earlier than the first IDLE cycle.
//    There is no back-to-back start from DONE.
//  - Address arithmetic: base+cnt wraps modulo 2^ADDR_W. Low PC bits are not masked.
// TESTING
//  1 pc=0x0000_1000, gnt immediate, bytes 0x13,0x05,0x10,0x00 -> mem_a 0x1000..0x1003;
//    cache_we pulse with winst=0x0010_0513, wpc=0x1000 exactly 6 cycles after gnt.
//  2 fetch_req with icache_hit=1 -> stays IDLE; mem_req, cache_we and busy all remain 0.
//  3 gnt held low 5 cycles -> mem_req stays 1, mem_a stays stable; refill completes normally
//    after gnt.
//  4 flush at the 3rd BUS cycle -> IDLE next cycle, mem_req=0, no cache_we/inst_valid;
//    the next request refills correctly.
//  5 rdy=0 for 3 cycles mid-BUS (memory also stalled) -> all outputs frozen; the result word is
//    unchanged vs the no-stall run.
//  6 rst asserted asynchronously mid-TAIL -> outputs 0 immediately, state IDLE, no write pulse.

Source files
------------

// File: rtl/icache_refill.sv
// icache miss-refill engine: four byte reads assembled little-endian into one word.
// Write pulse 6 cycles after grant; rdy=0 freezes everything, flush aborts in any state.
module icache_refill #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              fetch_req_i,
    input  logic [ADDR_W-1:0] fetch_pc_i,
    input  logic              icache_hit_i,
    input  logic              flush_i,
    output logic              mem_req_o,
    input  logic              mem_gnt_i,
    output logic [ADDR_W-1:0] mem_a_o,
    input  logic [7:0]        mem_din_i,
    output logic              cache_we_o,
    output logic [ADDR_W-1:0] cache_wpc_o,
    output logic [31:0]       cache_winst_o,
    output logic              inst_valid_o,
    output logic [31:0]       inst_o,
    output logic              busy_o
);

    typedef enum logic [2:0] {IDLE, WAIT_GNT, BUS, TAIL, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] base;
    logic [1:0]        cnt;
    logic [1:0]        byte_idx;
    logic [31:0]       word;
    logic [31:0]       inst_q;
    logic              we_q;

    // Byte on mem_din_i belongs to the address driven one cycle earlier.
    assign byte_idx = cnt - 2'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            base        <= '0;
            cnt         <= '0;
            word        <= '0;
            inst_q      <= '0;
            we_q        <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_a_o     <= '0;
            cache_wpc_o <= '0;
        end else if (rdy) begin
            we_q <= 1'b0;
            if (flush_i) begin
                state     <= IDLE;
                mem_req_o <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (fetch_req_i && !icache_hit_i) begin
                            base      <= fetch_pc_i;
                            mem_req_o <= 1'b1;
                            state     <= WAIT_GNT;
                        end
                    end
                    WAIT_GNT: begin
                        if (mem_gnt_i) begin
                            cnt     <= 2'd0;
                            mem_a_o <= base;
                            state   <= BUS;
                        end
                    end
                    BUS: begin
                        if (cnt != 2'd0) begin
                            word[{byte_idx, 3'b000} +: 8] <= mem_din_i;
                        end
                        cnt <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            state <= TAIL;
                        end else begin
                            mem_a_o <= base + ADDR_W'(cnt + 2'd1);
                        end
                    end
                    TAIL: begin
                        word[31:24] <= mem_din_i;
                        inst_q      <= {mem_din_i, word[23:0]};
                        cache_wpc_o <= base;
                        we_q        <= 1'b1;
                        mem_req_o   <= 1'b0;
                        state       <= DONE;
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // A flush arriving in DONE must kill the pulse in the same cycle.
    assign cache_we_o    = we_q & ~(flush_i & rdy);
    assign inst_valid_o  = we_q & ~(flush_i & rdy);
    assign cache_winst_o = inst_q;
    assign inst_o        = inst_q;
    assign busy_o        = (state != IDLE);

endmodule
